ula_reg_seq: RTL and testbench

ULA_REG_SEQ -- requirements
Module: ula_reg_seq

---
 rtl/ula_reg_seq.sv | 117 +++++++++++
 tb/tb_ula_reg_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_reg_seq.sv
// Register-file sequencer feeding an external ula: read operands, capture result/flags, write back.
// Latency: done 3 cycles after accept (2 with ULA_REG_SEQ_BYPASS_EN); one command per 3 (2) cycles.
// Backpressure: cmd_ready only in IDLE; commands presented while busy are ignored, never queued.
module ula_reg_seq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [ADDR_W-1:0] cmd_rt,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] SrcA,
  output logic [DATA_W-1:0] SrcB,
  output logic [2:0]        ULAControl,
  input  logic [DATA_W-1:0] ULAResult,
  input  logic              Flag_z,
  input  logic              CarryOut,
  output logic [DATA_W-1:0] result,
  output logic              res_z,
  output logic              res_co,
  output logic              done
);

  localparam int NREG = 1 << ADDR_W;

`ifdef ULA_REG_SEQ_BYPASS_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;
`endif

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   rf [NREG];
  logic [ADDR_W-1:0]   rd_q;
  logic                accept;
  logic                wb_we;
  logic [DATA_W-1:0]   wb_dat;
  logic                ld_we;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    wb_we     = 1'b0;
    wb_dat    = result;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
`ifdef ULA_REG_SEQ_BYPASS_EN
      // Write back straight from the ula on the same edge that captures the result.
      EXEC: begin
        wb_we     = 1'b1;
        wb_dat    = ULAResult;
        state_nxt = IDLE;
      end
`else
      EXEC: state_nxt = WB;
      WB: begin
        wb_we     = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Write-back owns the port on a same-address collision with the load port.
  assign ld_we = ld_en && (ld_addr != '0) && !(wb_we && (ld_addr == rd_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      rd_q       <= '0;
      SrcA       <= '0;
      SrcB       <= '0;
      ULAControl <= 3'b000;
      result     <= '0;
      res_z      <= 1'b0;
      res_co     <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= wb_we;
      if (accept) begin
        SrcA       <= rf[cmd_rs];
        SrcB       <= rf[cmd_rt];
        ULAControl <= cmd_op;
        rd_q       <= cmd_rd;
      end
      if (state == EXEC) begin
        result <= ULAResult;
        res_z  <= Flag_z;
        res_co <= CarryOut;
      end
      if (ld_we) rf[ld_addr] <= ld_data;
      // Entry 0 is never written, so it stays at its reset value of zero.
      if (wb_we && (rd_q != '0)) rf[rd_q] <= wb_dat;
    end
  end

endmodule

// File: tb/tb_ula_reg_seq.sv
// Bench for ula_reg_seq: behavioural ula drives the result inputs; a register-array model predicts results.
module tb_ula_reg_seq;

`ifdef ULA_REG_SEQ_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset, cmd_valid, cmd_ready, ld_en;
  logic [2:0] cmd_op, cmd_rs, cmd_rt, cmd_rd, ld_addr, ULAControl;
  logic [7:0] ld_data, SrcA, SrcB, ULAResult, result;
  logic       Flag_z, CarryOut, res_z, res_co, done;

  logic [7:0] model [8];
  int         total = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  ula_reg_seq #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .SrcA(SrcA), .SrcB(SrcB), .ULAControl(ULAControl),
    .ULAResult(ULAResult), .Flag_z(Flag_z), .CarryOut(CarryOut),
    .result(result), .res_z(res_z), .res_co(res_co), .done(done)
  );

  // Returns {zero, carry, result[7:0]}.
  function automatic logic [9:0] ula_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int   s;
    logic [7:0] r;
    logic co;
    co = 1'b0;
    r  = 8'd0;
    case (op)
      3'd0: begin s = int'(a) + int'(b); r = 8'(s % 256); co = (s > 255); end
      3'd1: begin r = 8'((int'(a) - int'(b) + 256) % 256); co = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (a < b) ? 8'd1 : 8'd0;
      3'd6: r = ~(a | b);
      default: r = 8'd0;
    endcase
    return {(r == 8'd0), co, r};
  endfunction

  always_comb {Flag_z, CarryOut, ULAResult} = ula_f(ULAControl, SrcA, SrcB);

  task automatic ld(input logic [2:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (a != 3'd0) model[a] = d;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input bit junk, input int ld_cyc,
                        input logic [2:0] la, input logic [7:0] ldd, output logic [7:0] r_out);
    logic [9:0] e;
    int w;
    w = 0;
    while (!cmd_ready && w < 10) begin @(posedge clk); #1; w++; end
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready);
    else passed++;
    e = ula_f(op, model[rs], model[rt]);
    cmd_valid = 1'b1; cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    total++;
    if ({SrcA, SrcB, ULAControl} !== {model[rs], model[rt], op})
      $display("FAIL operands: SrcA=%0d SrcB=%0d op=%b required %0d %0d %b",
               SrcA, SrcB, ULAControl, model[rs], model[rt], op);
    else passed++;
    for (int k = 1; k < LAT; k++) begin
      total++;
      if ({done, cmd_ready} !== 2'b00)
        $display("FAIL busy_cycle%0d: done=%b cmd_ready=%b required 0 0", k, done, cmd_ready);
      else passed++;
      if (junk && k == 1) begin
        cmd_valid = 1'b1; cmd_op = ~op; cmd_rs = rt; cmd_rt = rs; cmd_rd = 3'($urandom);
      end
      if (k == ld_cyc) begin ld_en = 1'b1; ld_addr = la; ld_data = ldd; end
      @(posedge clk); #1;
      cmd_valid = 1'b0; ld_en = 1'b0;
    end
    total++;
    if ({done, cmd_ready, result, res_z, res_co} !== {2'b11, e[7:0], e[9], e[8]})
      $display("FAIL completion: done=%b rdy=%b result=%0d z=%b co=%b required 1 1 %0d %b %b",
               done, cmd_ready, result, res_z, res_co, e[7:0], e[9], e[8]);
    else passed++;
    if (ld_cyc > 0 && la != 3'd0) model[la] = ldd;
    if (rd != 3'd0) model[rd] = e[7:0];
    r_out = result;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] v);
    do_cmd(3'd0, a, 3'd0, 3'd0, 1'b0, 0, 3'd0, 8'd0, v);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    total++;
    if ({cmd_ready, done, SrcA, SrcB, ULAControl, result, res_z, res_co} !== {2'b10, 29'd0})
      $display("FAIL reset_outputs: rdy=%b done=%b A=%0d B=%0d ctl=%b res=%0d z=%b co=%b required rdy=1, rest 0",
               cmd_ready, done, SrcA, SrcB, ULAControl, result, res_z, res_co);
    else passed++;
    for (int i = 0; i < 8; i++) read_reg(3'(i), v);
  endtask

  task automatic test_add_carry();
    logic [7:0] v;
    ld(3'd1, 8'd200); ld(3'd2, 8'd100);
    do_cmd(3'd0, 3'd1, 3'd2, 3'd3, 1'b0, 0, 3'd0, 8'd0, v);
    total++;
    if ({v, res_co, res_z} !== {8'd44, 2'b10})
      $display("FAIL add_carry: result=%0d co=%b z=%b required 44 1 0", v, res_co, res_z);
    else passed++;
    read_reg(3'd3, v);
    total++;
    if (v !== 8'd44) $display("FAIL add_rf3: rf3=%0d required 44", v);
    else passed++;
  endtask

  task automatic test_sub_slt();
    logic [7:0] v;
    ld(3'd1, 8'd5); ld(3'd2, 8'd8);
    do_cmd(3'd1, 3'd1, 3'd2, 3'd4, 1'b1, 0, 3'd0, 8'd0, v);
    do_cmd(3'd5, 3'd1, 3'd2, 3'd5, 1'b1, 0, 3'd0, 8'd0, v);
    read_reg(3'd4, v);
    total++;
    if (v !== 8'd253) $display("FAIL sub_rf4: rf4=%0d required 253", v);
    else passed++;
    read_reg(3'd5, v);
    total++;
    if (v !== 8'd1) $display("FAIL slt_rf5: rf5=%0d required 1", v);
    else passed++;
  endtask

  task automatic test_op111_and_r0();
    logic [7:0] v;
    do_cmd(3'd7, 3'd1, 3'd2, 3'd6, 1'b0, 0, 3'd0, 8'd0, v);
    total++;
    if ({v, res_z} !== {8'd0, 1'b1}) $display("FAIL op111: result=%0d z=%b required 0 1", v, res_z);
    else passed++;
    ld(3'd1, 8'd7);
    ld(3'd0, 8'd55);
    do_cmd(3'd0, 3'd1, 3'd1, 3'd0, 1'b0, 0, 3'd0, 8'd0, v);
    read_reg(3'd0, v);
    total++;
    if (v !== 8'd0) $display("FAIL r0_reads_zero: rf0=%0d required 0", v);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] v, a, b;
    a = 8'($urandom); b = 8'($urandom);
    ld(3'd1, a); ld(3'd2, b);
    do_cmd(3'd0, 3'd1, 3'd2, 3'd3, 1'b0, 0, 3'd0, 8'd0, v);
    do_cmd(3'd0, 3'd3, 3'd3, 3'd4, 1'b0, 0, 3'd0, 8'd0, v);
    total++;
    if (v !== 8'((2 * ((int'(a) + int'(b)) % 256)) % 256))
      $display("FAIL back_to_back: r4=%0d required %0d", v, 8'((2 * ((int'(a) + int'(b)) % 256)) % 256));
    else passed++;
  endtask

  task automatic test_ld_collision();
    logic [7:0] v;
    ld(3'd1, 8'd30); ld(3'd2, 8'd12);
    do_cmd(3'd0, 3'd1, 3'd2, 3'd5, 1'b0, LAT - 1, 3'd5, 8'd99, v);
    read_reg(3'd5, v);
    total++;
    if (v !== 8'd42) $display("FAIL wb_wins: rf5=%0d required 42", v);
    else passed++;
    do_cmd(3'd1, 3'd1, 3'd2, 3'd6, 1'b0, 1, 3'd7, 8'd77, v);
    read_reg(3'd7, v);
    total++;
    if (v !== 8'd77) $display("FAIL ld_while_busy: rf7=%0d required 77", v);
    else passed++;
  endtask

  task automatic test_reset_abort();
    logic [7:0] v;
    for (int c = 1; c < LAT; c++) begin
      ld(3'd1, 8'($urandom)); ld(3'd2, 8'($urandom)); ld(3'd3, 8'h5A);
      cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rs = 3'd1; cmd_rt = 3'd2; cmd_rd = 3'd3;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int k = 1; k < c; k++) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 8; i++) model[i] = 8'd0;
      total++;
      if ({cmd_ready, done, SrcA, SrcB, ULAControl, result, res_z, res_co} !== {2'b10, 29'd0})
        $display("FAIL abort_outputs_c%0d: rdy=%b done=%b A=%0d B=%0d res=%0d required rdy=1, rest 0",
                 c, cmd_ready, done, SrcA, SrcB, result);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0) $display("FAIL abort_no_done_c%0d: done=%b required 0", c, done);
      else passed++;
      read_reg(3'd3, v);
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int i = 1; i < 8; i++) ld(3'(i), 8'($urandom));
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) ld(3'($urandom), 8'($urandom));
      else do_cmd(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                  int'($urandom_range(0, LAT - 1)), 3'($urandom), 8'($urandom), v);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_rs = 3'd0; cmd_rt = 3'd0; cmd_rd = 3'd0;
    ld_en = 1'b0; ld_addr = 3'd0; ld_data = 8'd0;
    for (int i = 0; i < 8; i++) model[i] = 8'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_add_carry();
    test_sub_slt();
    test_op111_and_r0();
    test_back_to_back();
    test_ld_collision();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
